// File: rtl/decode_issue_buffer_pkg.sv
// Shared types for the decode/issue buffer: the decoded scoreboard entry and
// the buffer depth used at instantiation.
package decode_issue_buffer_pkg;

  localparam int unsigned DECODE_BUF_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  trans_id;
    logic [3:0]  fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } scoreboard_entry_t;

endpackage

// File: rtl/decode_issue_buffer_fifo.sv
// Circular-buffer storage: wrapping read/write pointers, occupancy counter,
// full/empty flags. Flush empties the buffer and blocks same-cycle push/pop.
module decode_issue_buffer_fifo #(
  parameter int unsigned  DATA_W = 8,
  parameter int unsigned  DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W:0]    count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; the counter alone defines validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/decode_issue_buffer.sv
// Elastic buffer between decode and issue; holds back presentation while a
// control-flow instruction handed to issue is still unresolved.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int unsigned  DEPTH = DECODE_BUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [$bits(scoreboard_entry_t)-1:0] decoded_instr_i,
  input  logic                                 decoded_instr_valid_i,
  input  logic                                 is_ctrl_flow_i,
  output logic                                 decoded_instr_ack_o,
  output logic [$bits(scoreboard_entry_t)-1:0] issue_instr_o,
  output logic                                 issue_instr_valid_o,
  output logic                                 issue_is_ctrl_flow_o,
  input  logic                                 issue_ack_i,
  input  logic                                 resolve_branch_i,
  output logic [PTR_W:0]                       count_o,
  output logic                                 branch_pending_o
);

  localparam int unsigned SBE_W   = $bits(scoreboard_entry_t);
  localparam int unsigned ENTRY_W = SBE_W + 1;

  typedef enum logic {IDLE, WAIT_RESOLVE} state_e;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] head;
  logic               full, empty, pop;

  // Acceptance ignores issue_ack_i so a full buffer never accepts.
  assign decoded_instr_ack_o  = decoded_instr_valid_i && !full && !flush_i;
  assign issue_instr_valid_o  = !empty && (state_q == IDLE) && !flush_i;
  assign pop                  = issue_instr_valid_o && issue_ack_i;
  assign issue_is_ctrl_flow_o = head[ENTRY_W-1];
  assign issue_instr_o        = head[SBE_W-1:0];
  assign branch_pending_o     = (state_q == WAIT_RESOLVE);

  decode_issue_buffer_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (decoded_instr_ack_o),
    .pop_i   (pop),
    .data_i  ({is_ctrl_flow_i, decoded_instr_i}),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  // A resolve seen in IDLE belongs to an older branch and is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (pop && issue_is_ctrl_flow_o) state_d = WAIT_RESOLVE;
      WAIT_RESOLVE: if (resolve_branch_i) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Self-checking bench for decode_issue_buffer: directed vector table, flush and
// async-reset sequences, pointer wrap, and randomized traffic vs. a queue model.
module tb_decode_issue_buffer;
  import decode_issue_buffer_pkg::*;

  localparam int unsigned DEPTH = DECODE_BUF_DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_instr_valid_o;
  logic              issue_is_ctrl_flow_o;
  logic              issue_ack_i;
  logic              resolve_branch_i;
  logic [PTR_W:0]    count_o;
  logic              branch_pending_o;

  always #5 clk_i = ~clk_i;

  decode_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .issue_is_ctrl_flow_o  (issue_is_ctrl_flow_o),
    .issue_ack_i           (issue_ack_i),
    .resolve_branch_i      (resolve_branch_i),
    .count_o               (count_o),
    .branch_pending_o      (branch_pending_o)
  );

  // Reference model: ordered queue of entries plus one "branch outstanding" bit.
  typedef struct {
    logic              ctrl;
    scoreboard_entry_t e;
  } model_ent_t;

  model_ent_t mq[$];
  logic       m_pend = 1'b0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic        v, c;
    logic [31:0] id;
    logic        a, r, f;
    logic        e_ack, e_vld;
    int          e_cnt;
    logic        e_pend;
    logic [31:0] e_head;
  } vec_t;

  vec_t vecs[$];

  function automatic scoreboard_entry_t mk(input logic [31:0] seed);
    scoreboard_entry_t e;
    e.pc       = seed;
    e.trans_id = seed[2:0];
    e.fu       = seed[6:3] ^ 4'hA;
    e.op       = seed[13:7];
    e.rs1      = seed[18:14];
    e.rs2      = seed[23:19];
    e.rd       = seed[28:24] ^ 5'h15;
    e.valid    = 1'b1;
    return e;
  endfunction

  function automatic vec_t tv(input logic v, input logic c, input int id,
                              input logic a, input logic r, input logic f,
                              input logic e_ack, input logic e_vld, input int e_cnt,
                              input logic e_pend, input int e_head);
    vec_t t;
    t.v = v; t.c = c; t.id = 32'(id); t.a = a; t.r = r; t.f = f;
    t.e_ack = e_ack; t.e_vld = e_vld; t.e_cnt = e_cnt;
    t.e_pend = e_pend; t.e_head = 32'(e_head);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance it.
  task automatic cycle(input logic v, input logic c, input logic [31:0] seed,
                       input logic a, input logic r, input logic f);
    logic       exp_ack, exp_vld;
    model_ent_t ent;
    @(negedge clk_i);
    decoded_instr_valid_i = v;
    is_ctrl_flow_i        = c;
    decoded_instr_i       = mk(seed);
    issue_ack_i           = a;
    resolve_branch_i      = r;
    flush_i               = f;
    #1;
    exp_ack = v && (mq.size() < DEPTH) && !f;
    exp_vld = (mq.size() != 0) && !m_pend && !f;
    chk("ack", 64'(decoded_instr_ack_o), 64'(exp_ack));
    chk("valid", 64'(issue_instr_valid_o), 64'(exp_vld));
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("pending", 64'(branch_pending_o), 64'(m_pend));
    if (exp_vld) begin
      chk("head", 64'(issue_instr_o), 64'(mq[0].e));
      chk("head_ctrl", 64'(issue_is_ctrl_flow_o), 64'(mq[0].ctrl));
    end
    if (f) begin
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (exp_vld && a) begin
        ent = mq.pop_front();
        if (ent.ctrl) m_pend = 1'b1;
      end else if (r) begin
        m_pend = 1'b0;
      end
      if (exp_ack) begin
        ent.ctrl = c;
        ent.e    = mk(seed);
        mq.push_back(ent);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; decoded_instr_i = mk(32'h0);
    decoded_instr_valid_i = 1'b0; is_ctrl_flow_i = 1'b0;
    issue_ack_i = 1'b0; resolve_branch_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_count", 64'(count_o), 64'(0));
    chk("reset_valid", 64'(issue_instr_valid_o), 64'(0));
    chk("reset_pending", 64'(branch_pending_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    // In-order stream, full buffer, and branch block with resolve.
    vecs.push_back(tv(1,0, 1,1,0,0, 1,0,0,0, 0));
    vecs.push_back(tv(1,0, 2,1,0,0, 1,1,1,0, 1));
    vecs.push_back(tv(1,0, 3,1,0,0, 1,1,1,0, 2));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,1,0, 3));
    vecs.push_back(tv(0,0, 0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(tv(1,0, 4,0,0,0, 1,0,0,0, 0));
    vecs.push_back(tv(1,0, 5,0,0,0, 1,1,1,0, 4));
    vecs.push_back(tv(1,0, 6,0,0,0, 1,1,2,0, 4));
    vecs.push_back(tv(1,0, 7,0,0,0, 1,1,3,0, 4));
    vecs.push_back(tv(1,0, 8,0,0,0, 0,1,4,0, 4));
    vecs.push_back(tv(1,0, 8,1,0,0, 0,1,4,0, 4));
    vecs.push_back(tv(1,0, 8,0,0,0, 1,1,3,0, 5));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,4,0, 5));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,3,0, 6));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,2,0, 7));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,1,0, 8));
    vecs.push_back(tv(0,0, 0,0,0,0, 0,0,0,0, 0));
    vecs.push_back(tv(1,1, 9,1,0,0, 1,0,0,0, 0));
    vecs.push_back(tv(1,0,10,1,0,0, 1,1,1,0, 9));
    vecs.push_back(tv(1,0,11,1,0,0, 1,0,1,1, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(tv(0,0,0,1,0,0, 0,0,2,1, 0));
    vecs.push_back(tv(0,0, 0,1,1,0, 0,0,2,1, 0));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,2,0,10));
    vecs.push_back(tv(0,0, 0,1,0,0, 0,1,1,0,11));
    vecs.push_back(tv(0,0, 0,0,0,0, 0,0,0,0, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].v, vecs[i].c, vecs[i].id, vecs[i].a, vecs[i].r, vecs[i].f);
      chk($sformatf("vec%0d_ack", i), 64'(decoded_instr_ack_o), 64'(vecs[i].e_ack));
      chk($sformatf("vec%0d_valid", i), 64'(issue_instr_valid_o), 64'(vecs[i].e_vld));
      chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_pending", i), 64'(branch_pending_o), 64'(vecs[i].e_pend));
      if (vecs[i].e_vld)
        chk($sformatf("vec%0d_head", i), 64'(issue_instr_o), 64'(mk(vecs[i].e_head)));
    end

    // Flush with three buffered entries, branch pending, and a concurrent push.
    cycle(1,1,32'd20,0,0,0);
    cycle(1,0,32'd21,1,0,0);
    cycle(1,0,32'd22,1,0,0);
    cycle(1,0,32'd23,1,0,0);
    cycle(1,0,32'd24,1,0,1);
    cycle(0,0,32'd0,0,0,0);
    chk("flush_count", 64'(count_o), 64'(0));
    chk("flush_pending", 64'(branch_pending_o), 64'(0));
    chk("flush_valid", 64'(issue_instr_valid_o), 64'(0));

    // Asynchronous reset between clock edges with two entries held.
    cycle(1,0,32'd40,0,0,0);
    cycle(1,0,32'd41,0,0,0);
    cycle(0,0,32'd0,0,0,0);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_count", 64'(count_o), 64'(0));
    chk("async_rst_valid", 64'(issue_instr_valid_o), 64'(0));
    chk("async_rst_pending", 64'(branch_pending_o), 64'(0));
    decoded_instr_valid_i = 1'b1;
    #1;
    chk("rst_ack_follows_valid", 64'(decoded_instr_ack_o), 64'(1));
    mq.delete();
    m_pend = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    decoded_instr_valid_i = 1'b0;
    cycle(1,0,32'd50,1,0,0);
    cycle(0,0,32'd0,1,0,0);
    cycle(0,0,32'd0,0,0,0);

    // Pointer wrap: back-to-back push/pop pairs through the ring.
    for (int i = 0; i < 10; i++) cycle(1,0,32'(100 + i),1,0,0);
    cycle(0,0,32'd0,1,0,0);
    cycle(0,0,32'd0,0,0,0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 10) < 7, ($urandom % 10) < 2, $urandom,
            ($urandom % 10) < 6, ($urandom % 100) < 15, ($urandom % 100) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
